match_logger: RTL and testbench

Downstream consumer of the serial pattern detector. Watches the detector's `match` flag and 10-bit window `d`. On every new match it captures `d` into a small first-word-fall-through FIFO and counts the event. A host drains the captured windows through a pop handshake. Overflow is flagged sticky, so no lost event goes unnoticed.

---
 rtl/match_logger.sv | 72 +++++++
 tb/tb_match_logger.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/match_logger.sv
// match_logger: captures detector windows on rising match into a FWFT FIFO with event count and sticky overflow
module match_logger #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       match,
   input  logic [WIDTH-1:0]           d,
   input  logic                       clr,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [CNT_W-1:0]           match_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_match_q;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_overflow;
   logic [CNT_W-1:0] r_count;
   logic             w_cap;
   logic             w_pop;
   logic             w_push;
   assign w_cap       = match & ~r_match_q;
   assign rd_valid    = r_level != '0;
   assign full        = r_level == LW'(DEPTH);
   assign w_pop       = rd_en & rd_valid;
   // a full FIFO still accepts a push when the same edge frees a slot
   assign w_push      = w_cap & (~full | w_pop);
   assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : '0;
   assign level       = r_level;
   assign overflow    = r_overflow;
   assign match_count = r_count;
   // storage write; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (w_push & ~clr) r_mem[r_wr_ptr] <= d;
   end
   // edge detector, pointers, occupancy, overflow flag and saturating event counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_match_q  <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end else begin
         r_match_q <= match;
         if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_cap & ~w_push) r_overflow <= 1'b1;
            if (w_cap & (r_count != '1)) r_count <= r_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_match_logger.sv
// tb_match_logger: directed and randomized checks of match_logger against a queue-based reference model
module tb_match_logger;
   localparam int DEPTH = 4;
   localparam int MAXC = 255;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       match = 1'b0;
   logic [9:0] d = '0;
   logic       clr = 1'b0;
   logic       rd_en = 1'b0;
   logic [9:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic [2:0] level;
   logic       overflow;
   logic [7:0] match_count;
   int checks = 0;
   int errors = 0;
   int q[$];
   int m_cnt = 0;
   int m_ovf = 0;
   int m_prev = 0;

   match_logger #(.WIDTH(10), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .match(match), .d(d), .clr(clr), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .level(level),
      .overflow(overflow), .match_count(match_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = 0;
      m_ovf = 0;
      m_prev = 0;
   endtask

   task automatic model_edge(input logic m, input logic re, input logic c, input logic [9:0] dv);
      bit cap;
      bit pop;
      cap = m && !m_prev;
      pop = re && q.size() > 0;
      m_prev = m;
      if (c) begin
         q.delete();
         m_cnt = 0;
         m_ovf = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (cap) begin
            if (q.size() < DEPTH) q.push_back(int'(dv));
            else m_ovf = 1;
            m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
         end
      end
   endtask

   task automatic check_all();
      chk("rd_valid", rd_valid, (q.size() != 0) ? 1 : 0);
      chk("rd_data", rd_data, (q.size() != 0) ? q[0] : 0);
      chk("level", level, q.size());
      chk("full", full, (q.size() == DEPTH) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      chk("match_count", match_count, m_cnt);
   endtask

   task automatic step(input logic m, input logic [9:0] dv, input logic re, input logic c);
      @(negedge clk);
      match = m;
      d = dv;
      rd_en = re;
      clr = c;
      @(posedge clk);
      model_edge(m, re, c, dv);
      #1 check_all();
   endtask

   task automatic pulse(input logic [9:0] dv);
      step(1'b1, dv, 1'b0, 1'b0);
      step(1'b0, 10'h0, 1'b0, 1'b0);
   endtask

   task automatic drain_expect(input int v, input string tag);
      chk(tag, rd_data, v);
      step(1'b0, 10'h0, 1'b1, 1'b0);
   endtask

   initial begin
      model_reset();
      #3 check_all();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 10'($urandom), 1'b0, 1'b0);
      chk("idle_count", match_count, 0);

      for (int i = 0; i < 3; i++) step(1'b1, 10'h2A5, 1'b0, 1'b0);
      step(1'b0, 10'h0, 1'b0, 1'b0);
      chk("single_data", rd_data, 10'h2A5);
      chk("single_level", level, 1);
      chk("single_count", match_count, 1);
      step(1'b0, 10'h0, 1'b1, 1'b0);
      chk("single_pop_valid", rd_valid, 0);
      chk("single_pop_data", rd_data, 0);

      step(1'b0, 10'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) pulse(10'(i));
      chk("fill_full", full, 1);
      chk("fill_ovf_before", overflow, 0);
      pulse(10'd5);
      chk("fill_ovf", overflow, 1);
      chk("fill_count", match_count, 5);
      for (int i = 1; i <= 4; i++) drain_expect(i, "fill_drain");
      chk("fill_empty", rd_valid, 0);
      step(1'b0, 10'h0, 1'b1, 1'b0);

      step(1'b0, 10'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) pulse(10'(i));
      step(1'b1, 10'd9, 1'b1, 1'b0);
      chk("pp_level", level, 4);
      chk("pp_ovf", overflow, 0);
      step(1'b0, 10'h0, 1'b0, 1'b0);
      drain_expect(2, "pp_drain");
      drain_expect(3, "pp_drain");
      drain_expect(4, "pp_drain");
      drain_expect(9, "pp_drain");
      chk("pp_empty", rd_valid, 0);

      step(1'b1, 10'h3, 1'b1, 1'b0);
      step(1'b0, 10'h3, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 10'($urandom), 1'b1, 1'b0);
         step(1'b0, 10'($urandom), 1'b1, 1'b0);
      end
      chk("sat_count", match_count, 255);
      pulse(10'h11);
      chk("sat_hold", match_count, 255);
      step(1'b0, 10'h0, 1'b0, 1'b0);
      step(1'b1, 10'h155, 1'b0, 1'b1);
      chk("clr_count", match_count, 0);
      chk("clr_level", level, 0);
      chk("clr_ovf", overflow, 0);
      step(1'b1, 10'h155, 1'b0, 1'b0);
      chk("clr_no_recap", level, 0);
      step(1'b0, 10'h0, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 2) != 0), 10'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 60) == 0));

      step(1'b0, 10'h0, 1'b0, 1'b1);
      pulse(10'h101);
      pulse(10'h102);
      pulse(10'h103);
      chk("ar_level_pre", level, 3);
      #2 rst = 1'b0;
      #1 model_reset();
      check_all();
      chk("ar_level", level, 0);
      match = 1'b1;
      d = 10'h3C3;
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      model_edge(1'b1, 1'b0, 1'b0, 10'h3C3);
      #1 check_all();
      chk("ar_recap_level", level, 1);
      chk("ar_recap_data", rd_data, 10'h3C3);
      step(1'b1, 10'h3C3, 1'b0, 1'b0);
      chk("ar_single", level, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
